// File: rtl/ysyx_25040129_clint_timer.sv
// ysyx_25040129_clint_timer -- core-local interruptor (CLINT) with AXI4-lite slave.
//
// Purpose:
//   Holds a free-running 64-bit mtime counter with a prescaler. Also holds per-hart
//   mtimecmp and msip registers. Drives per-hart timer (mtip) and software (msip)
//   interrupt lines.
//
// Register map (on addr[ADDR_W-1:0], word aligned):
//   0x0000+4h msip[h] (bit 0)
//   0x4000+8h mtimecmp[h] lo
//   0x4004+8h mtimecmp[h] hi
//   0xBFF8    mtime lo
//   0xBFFC    mtime hi
//   Any other offset is unmapped and answers SLVERR.
//
// Optional feature: CLINT_MTIME_WR_EN
//   Defined   : mtime is writable.
//   Undefined : mtime is read-only, and writes to it answer SLVERR.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   ar*/r*               AXI4-lite read channel (1-cycle read latency, no pipelining)
//   aw*/w*/b*            AXI4-lite write channel (AW and W accepted independently)
//   mtip[NHART]          registered (mtime >= mtimecmp[h])
//   msip[NHART]          msip register bits

// Per-hart state: mtimecmp, msip, registered timer compare.
module ysyx_25040129_clint_hart (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] mtime,
   input  logic        cmp_we,
   input  logic        cmp_hi,
   input  logic        sip_we,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic [63:0] mtimecmp,
   output logic        msip,
   output logic        mtip
);
   logic [31:0] cmp_old, cmp_new;

   always_comb begin
      cmp_old = cmp_hi ? mtimecmp[63:32] : mtimecmp[31:0];
      cmp_new = cmp_old;
      for (int b = 0; b < 4; b++)
         if (wstrb[b]) cmp_new[8*b +: 8] = wdata[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mtimecmp <= '1;
         msip     <= 1'b0;
         mtip     <= 1'b0;
      end else begin
         if (cmp_we) begin
            if (cmp_hi) mtimecmp[63:32] <= cmp_new;
            else        mtimecmp[31:0]  <= cmp_new;
         end
         if (sip_we && wstrb[0]) msip <= wdata[0];
         // Compare uses pre-edge values, so mtip lags mtime/mtimecmp by one cycle.
         mtip <= (mtime >= mtimecmp);
      end
   end
endmodule

module ysyx_25040129_clint_timer #(
   parameter int NHART    = 1,
   parameter int TICK_DIV = 1,
   parameter int ADDR_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      araddr,
   input  logic             arvalid,
   output logic             arready,
   output logic [31:0]      rdata,
   output logic [1:0]       rresp,
   output logic             rvalid,
   input  logic             rready,
   input  logic [31:0]      awaddr,
   input  logic             awvalid,
   output logic             awready,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wstrb,
   input  logic             wvalid,
   output logic             wready,
   output logic [1:0]       bresp,
   output logic             bvalid,
   input  logic             bready,
   output logic [NHART-1:0] mtip,
   output logic [NHART-1:0] msip
);
`ifdef CLINT_MTIME_WR_EN
   localparam bit MTIME_WR = 1'b1;
`else
   localparam bit MTIME_WR = 1'b0;
`endif

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {K_NONE, K_MSIP, K_CMP, K_MTIME} kind_t;
   typedef struct packed {
      kind_t      kind;
      logic [2:0] hart;
      logic       hi;
   } dec_t;

   function automatic dec_t decode(input logic [ADDR_W-1:0] a);
      dec_t        d;
      logic [31:0] o;
      o      = 32'(a) & 32'hFFFF_FFFC;
      d.kind = K_NONE;
      d.hart = '0;
      d.hi   = 1'b0;
      if (o < 32'(4*NHART)) begin
         d.kind = K_MSIP;
         d.hart = o[4:2];
      end else if (o >= 32'h4000 && o < 32'h4000 + 32'(8*NHART)) begin
         d.kind = K_CMP;
         d.hart = o[5:3];
         d.hi   = o[2];
      end else if (o == 32'hBFF8 || o == 32'hBFFC) begin
         d.kind = K_MTIME;
         d.hi   = o[2];
      end
      return d;
   endfunction

   logic [63:0]            mtime;
   logic [15:0]            psc;
   logic                   wrap;
   logic [NHART-1:0][63:0] cmp_v;

   // ---------------- read channel ----------------
   typedef enum logic {R_IDLE, R_RESP} rstate_t;
   rstate_t     rstate, rstate_nx;
   dec_t        rdec;
   logic [31:0] rd_val;
   logic        rd_err;

   always_comb begin
      rdec   = decode(araddr[ADDR_W-1:0]);
      rd_val = '0;
      rd_err = 1'b0;
      case (rdec.kind)
         K_MSIP:  for (int h = 0; h < NHART; h++)
                     if (rdec.hart == 3'(h)) rd_val = {31'b0, msip[h]};
         K_CMP:   for (int h = 0; h < NHART; h++)
                     if (rdec.hart == 3'(h))
                        rd_val = rdec.hi ? cmp_v[h][63:32] : cmp_v[h][31:0];
         K_MTIME: rd_val = rdec.hi ? mtime[63:32] : mtime[31:0];
         default: rd_err = 1'b1;
      endcase
   end

   always_comb begin
      rstate_nx = rstate;
      case (rstate)
         R_IDLE:  if (arvalid) rstate_nx = R_RESP;
         R_RESP:  if (rready)  rstate_nx = R_IDLE;
         default: rstate_nx = R_IDLE;
      endcase
   end

   assign arready = (rstate == R_IDLE);
   assign rvalid  = (rstate == R_RESP);

   always_ff @(posedge clk) begin
      if (!rst) begin
         rstate <= R_IDLE;
         rdata  <= '0;
         rresp  <= OKAY;
      end else begin
         rstate <= rstate_nx;
         if (rstate == R_IDLE && arvalid) begin
            rdata <= rd_val;
            rresp <= rd_err ? SLVERR : OKAY;
         end
      end
   end

   // ---------------- write channel ----------------
   typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_t;
   wstate_t     wstate, wstate_nx;
   logic [31:0] awaddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_hs, w_hs, aw_have, w_have, wr_fire, wr_err;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   dec_t        wdec;
   logic        mt_we;
   logic [NHART-1:0] cmp_we, sip_we;
   logic [31:0] mt_old, mt_new;

   assign awready = (wstate == W_IDLE) || (wstate == W_WAIT_AW);
   assign wready  = (wstate == W_IDLE) || (wstate == W_WAIT_W);
   assign bvalid  = (wstate == W_RESP);
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   // An address/data beat is "held" once latched or while it is handshaking now.
   assign aw_have = aw_hs || (wstate == W_WAIT_W);
   assign w_have  = w_hs  || (wstate == W_WAIT_AW);
   assign wr_fire = aw_have && w_have;
   assign wr_addr = (wstate == W_WAIT_W)  ? awaddr_q : awaddr;
   assign wr_data = (wstate == W_WAIT_AW) ? wdata_q  : wdata;
   assign wr_strb = (wstate == W_WAIT_AW) ? wstrb_q  : wstrb;

   always_comb begin
      wdec   = decode(wr_addr[ADDR_W-1:0]);
      wr_err = (wdec.kind == K_NONE) || (wdec.kind == K_MTIME && !MTIME_WR);
      mt_we  = wr_fire && (wdec.kind == K_MTIME) && MTIME_WR;
      cmp_we = '0;
      sip_we = '0;
      for (int h = 0; h < NHART; h++) begin
         if (wr_fire && wdec.kind == K_CMP  && wdec.hart == 3'(h)) cmp_we[h] = 1'b1;
         if (wr_fire && wdec.kind == K_MSIP && wdec.hart == 3'(h)) sip_we[h] = 1'b1;
      end
   end

   always_comb begin
      wstate_nx = wstate;
      case (wstate)
         W_IDLE: begin
            if (wr_fire)    wstate_nx = W_RESP;
            else if (aw_hs) wstate_nx = W_WAIT_W;
            else if (w_hs)  wstate_nx = W_WAIT_AW;
         end
         W_WAIT_W:  if (wr_fire) wstate_nx = W_RESP;
         W_WAIT_AW: if (wr_fire) wstate_nx = W_RESP;
         W_RESP:    if (bready)  wstate_nx = W_IDLE;
         default:   wstate_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wstate   <= W_IDLE;
         bresp    <= OKAY;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         wstate <= wstate_nx;
         if (aw_hs) awaddr_q <= awaddr;
         if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (wr_fire) bresp <= wr_err ? SLVERR : OKAY;
      end
   end

   // ---------------- mtime + prescaler ----------------
   assign wrap = (psc == 16'(TICK_DIV - 1));

   always_comb begin
      mt_old = wdec.hi ? mtime[63:32] : mtime[31:0];
      mt_new = mt_old;
      for (int b = 0; b < 4; b++)
         if (wr_strb[b]) mt_new[8*b +: 8] = wr_data[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         psc   <= '0;
         mtime <= '0;
      end else begin
         psc <= wrap ? 16'd0 : psc + 16'd1;
         // A software write replaces the increment; a low-word write never carries.
         if (mt_we) begin
            if (wdec.hi) mtime[63:32] <= mt_new;
            else         mtime[31:0]  <= mt_new;
         end else if (wrap) begin
            mtime <= mtime + 64'd1;
         end
      end
   end

   // ---------------- per-hart state ----------------
   for (genvar h = 0; h < NHART; h++) begin : g_hart
      ysyx_25040129_clint_hart u_hart (
         .clk      (clk),
         .rst      (rst),
         .mtime    (mtime),
         .cmp_we   (cmp_we[h]),
         .cmp_hi   (wdec.hi),
         .sip_we   (sip_we[h]),
         .wdata    (wr_data),
         .wstrb    (wr_strb),
         .mtimecmp (cmp_v[h]),
         .msip     (msip[h]),
         .mtip     (mtip[h])
      );
   end

   // Address bits above ADDR_W are ignored by design.
   logic unused_addr;
   assign unused_addr = ^{araddr[31:ADDR_W], wr_addr[31:ADDR_W]};
endmodule

// File: tb/tb_ysyx_25040129_clint_timer.sv
module tb_ysyx_25040129_clint_timer;
   logic        clk, rst;
   // dut: NHART=2, TICK_DIV=1
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;
   logic [1:0]  mtip, msip;
   // dut4: NHART=1, TICK_DIV=4 (read channel only exercised)
   logic [31:0] a4_araddr, a4_rdata, a4_awaddr, a4_wdata;
   logic        a4_arvalid, a4_arready, a4_rvalid, a4_rready;
   logic [1:0]  a4_rresp, a4_bresp;
   logic        a4_awvalid, a4_awready, a4_wvalid, a4_wready, a4_bvalid, a4_bready;
   logic [3:0]  a4_wstrb;
   logic        a4_mtip, a4_msip;

   int n_tests = 0, n_fail = 0;
   logic [63:0] cyc;  // cycles since reset release == expected mtime of dut

   ysyx_25040129_clint_timer #(.NHART(2), .TICK_DIV(1), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
      .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
      .bvalid(bvalid), .bready(bready), .mtip(mtip), .msip(msip));

   ysyx_25040129_clint_timer #(.NHART(1), .TICK_DIV(4), .ADDR_W(16)) dut4 (
      .clk(clk), .rst(rst), .araddr(a4_araddr), .arvalid(a4_arvalid), .arready(a4_arready),
      .rdata(a4_rdata), .rresp(a4_rresp), .rvalid(a4_rvalid), .rready(a4_rready),
      .awaddr(a4_awaddr), .awvalid(a4_awvalid), .awready(a4_awready), .wdata(a4_wdata),
      .wstrb(a4_wstrb), .wvalid(a4_wvalid), .wready(a4_wready), .bresp(a4_bresp),
      .bvalid(a4_bvalid), .bready(a4_bready), .mtip(a4_mtip), .msip(a4_msip));

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!rst) cyc <= 64'd0;
      else      cyc <= cyc + 64'd1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
      $fatal(1);
   end

   // All bus tasks start and end just after a falling edge.
   task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                     output logic rv, output logic [63:0] ex);
      araddr = a; arvalid = 1'b1; ex = cyc;
      @(negedge clk);
      arvalid = 1'b0; rv = rvalid; d = rdata; r = rresp;
      @(negedge clk);
   endtask

   task automatic rd4(input logic [31:0] a, output logic [31:0] d);
      a4_araddr = a; a4_arvalid = 1'b1;
      @(negedge clk);
      a4_arvalid = 1'b0; d = a4_rdata;
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [1:0] r, output logic bv);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; bv = bvalid; r = bresp;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; logic rv; logic [63:0] ex;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
         n_fail++; $display("FAIL reset_hs: got %b exp 11100", {arready, awready, wready, rvalid, bvalid});
      end
      n_tests++;
      if ({rdata, rresp, bresp, msip, mtip} !== 40'd0) begin
         n_fail++; $display("FAIL reset_out: got rdata=%h msip=%b mtip=%b exp 0", rdata, msip, mtip);
      end
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rd(32'hBFF8, d, r, rv, ex);
      n_tests++;
      if (rv !== 1'b1 || r !== 2'b00 || d !== 32'd10) begin
         n_fail++; $display("FAIL mtime_lo: got rv=%b resp=%b data=%0d exp rv=1 resp=00 data=10", rv, r, d);
      end
      rd(32'hBFFC, d, r, rv, ex);
      n_tests++;
      if (d !== 32'd0 || r !== 2'b00) begin
         n_fail++; $display("FAIL mtime_hi: got %h/%b exp 0/00", d, r);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] d1, d2;
      rd4(32'hBFF8, d1);
      repeat (38) @(negedge clk);
      rd4(32'hBFF8, d2);
      n_tests++;
      if (d2 - d1 !== 32'd10) begin
         n_fail++; $display("FAIL prescale: got diff %0d exp 10", d2 - d1);
      end
   endtask

   task automatic test_mtip();
      logic [31:0] d; logic [1:0] r; logic rv, bv; logic [63:0] ex; int bad;
      do_reset();
      wr(32'h4004, 32'h0, 4'hF, r, bv);
      n_tests++;
      if (bv !== 1'b1 || r !== 2'b00) begin
         n_fail++; $display("FAIL cmp_hi_wr: got bv=%b resp=%b exp 1/00", bv, r);
      end
      wr(32'h4000, 32'h20, 4'hF, r, bv);
      bad = 0;
      // mtip at this sample reflects mtime one cycle earlier: high once cyc >= 0x21.
      for (int i = 0; i < 36; i++) begin
         if (bad == 0 && mtip[0] !== (cyc >= 64'h21)) begin
            bad = 1;
            $display("FAIL mtip_edge: got %b exp %b at mtime %0d", mtip[0], (cyc >= 64'h21), cyc);
         end
         @(negedge clk);
      end
      n_tests++;
      if (bad != 0) n_fail++;
      rd(32'h4000, d, r, rv, ex);
      n_tests++;
      if (d !== 32'h20 || r !== 2'b00) begin
         n_fail++; $display("FAIL cmp_rd: got %h/%b exp 20/00", d, r);
      end
      wr(32'h4004, 32'hFFFF_FFFF, 4'hF, r, bv);
      n_tests++;
      if (mtip !== 2'b00) begin
         n_fail++; $display("FAIL mtip_clear: got %b exp 00", mtip);
      end
   endtask

   task automatic test_msip();
      logic [31:0] d; logic [1:0] r; logic rv, bv; logic [63:0] ex;
      wr(32'h0004, 32'h1, 4'b0001, r, bv);
      n_tests++;
      if (msip !== 2'b10 || r !== 2'b00) begin
         n_fail++; $display("FAIL msip_set: got msip=%b resp=%b exp 10/00", msip, r);
      end
      wr(32'h0000, 32'h1, 4'b0000, r, bv);
      n_tests++;
      if (msip !== 2'b10 || r !== 2'b00 || bv !== 1'b1) begin
         n_fail++; $display("FAIL strb0: got msip=%b resp=%b exp 10/00", msip, r);
      end
      rd(32'h0004, d, r, rv, ex);
      n_tests++;
      if (d !== 32'h1) begin
         n_fail++; $display("FAIL msip_rd: got %h exp 1", d);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      awaddr = 32'h0004; awvalid = 1'b1; bready = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      awvalid = 1'b0;
      n_tests++;
      if ({awready, wready, bvalid} !== 3'b010) begin
         n_fail++; $display("FAIL aw_latched: got %b exp 010", {awready, wready, bvalid});
      end
      repeat (2) @(negedge clk);
      wdata = 32'h0; wstrb = 4'b0001; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      n_tests++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || msip !== 2'b00) begin
         n_fail++; $display("FAIL split_wr: got bv=%b resp=%b msip=%b exp 1/00/00", bvalid, bresp, msip);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bvalid !== 1'b1 || wready !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL b_hold: got %0d drops exp 0", bad);
      end
      bready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || msip !== 2'b00) begin
         n_fail++; $display("FAIL b_done: got bv=%b awready=%b exp 0/1", bvalid, awready);
      end
   endtask

   task automatic test_errors();
      logic [31:0] d, exp_d; logic [1:0] r, exp_r; logic rv, bv; logic [63:0] ex;
      rd(32'h1000, d, r, rv, ex);
      n_tests++;
      if (d !== 32'd0 || r !== 2'b10) begin
         n_fail++; $display("FAIL rd_unmapped: got %h/%b exp 0/10", d, r);
      end
      wr(32'h0008, 32'h1, 4'hF, r, bv);
      n_tests++;
      if (r !== 2'b10 || msip !== 2'b00) begin
         n_fail++; $display("FAIL wr_hart2: got resp=%b msip=%b exp 10/00", r, msip);
      end
      wr(32'h4010, 32'h0, 4'hF, r, bv);
      n_tests++;
      if (r !== 2'b10) begin
         n_fail++; $display("FAIL wr_cmp2: got %b exp 10", r);
      end
      wr(32'hBFF8, 32'h0, 4'hF, r, bv);
`ifdef CLINT_MTIME_WR_EN
      exp_r = 2'b00;
`else
      exp_r = 2'b10;
`endif
      n_tests++;
      if (r !== exp_r) begin
         n_fail++; $display("FAIL wr_mtime: got %b exp %b", r, exp_r);
      end
      rd(32'hBFF8, d, r, rv, ex);
`ifdef CLINT_MTIME_WR_EN
      exp_d = 32'd1;
`else
      exp_d = ex[31:0];
`endif
      n_tests++;
      if (d !== exp_d) begin
         n_fail++; $display("FAIL mtime_after_wr: got %0d exp %0d", d, exp_d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r; logic rv; logic [63:0] ex;
      rready = 1'b0; araddr = 32'hBFF8; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      n_tests++;
      if (rvalid !== 1'b1 || arready !== 1'b0) begin
         n_fail++; $display("FAIL in_resp: got rv=%b arready=%b exp 1/0", rvalid, arready);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || rdata !== 32'd0) begin
         n_fail++; $display("FAIL rst_abort: got rv=%b arready=%b rdata=%h exp 0/1/0", rvalid, arready, rdata);
      end
      rst = 1'b1; rready = 1'b1;
      repeat (5) @(negedge clk);
      rd(32'hBFF8, d, r, rv, ex);
      n_tests++;
      if (d !== 32'd5 || rv !== 1'b1) begin
         n_fail++; $display("FAIL restart: got %0d exp 5", d);
      end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
      a4_araddr = '0; a4_arvalid = 1'b0; a4_rready = 1'b1;
      a4_awaddr = '0; a4_awvalid = 1'b0; a4_wdata = '0; a4_wstrb = '0; a4_wvalid = 1'b0;
      a4_bready = 1'b1;
      @(negedge clk);
      test_reset();
      test_prescale();
      test_mtip();
      test_msip();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
